// File: rtl/nts_pkg.sv
// Shared constants, state encoding and per-word header check for the NTS RX preprocessor.
package nts_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL       = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
    localparam logic [15:0] NTP_PORT_DEFAULT = 16'd123;
    localparam logic [15:0] IP_FRAG_MASK     = 16'h3fff;
    localparam logic [2:0]  LAST_HDR_WORD    = 3'd4;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_DECIDED = 3'd3,
        ST_DISCARD = 3'd4
    } nts_state_e;

    // Byte 0 of the word sits in [63:56]; each word is judged on its own so nothing is buffered.
    function automatic logic word_ok(input logic [2:0]  idx,
                                     input logic [63:0] d,
                                     input logic [47:0] mac,
                                     input logic [31:0] ip,
                                     input logic [15:0] port);
        case (idx)
            3'd0:    return d[63:16] == mac;
            3'd1:    return (d[31:16] == ETHERTYPE_IPV4) && (d[15:8] == IP_VER_IHL);
            3'd2:    return ((d[31:16] & IP_FRAG_MASK) == 16'h0) && (d[7:0] == IP_PROTO_UDP);
            3'd3:    return d[15:0] == ip[31:16];
            3'd4:    return (d[63:48] == ip[15:0]) && (d[31:16] == port);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/nts_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module nts_sat_counter (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            o_count <= 32'h0;
        else if (i_inc && (o_count != 32'hffff_ffff))
            o_count <= o_count + 32'd1;
    end

endmodule

// File: rtl/nts_rx_preprocessor.sv
// Screens incoming MAC words for NTP/UDP/IPv4 frames addressed to this host and
// emits a one-cycle process pulse plus match / no-match / bad frame statistics.
module nts_rx_preprocessor
    import nts_pkg::*;
#(
    parameter logic [15:0] NTP_PORT = NTP_PORT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rx_data_valid,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_bad_frame,
    input  logic        i_rx_good_frame,
    input  logic [47:0] i_mac_addr,
    input  logic [31:0] i_ip_addr,
    output logic        o_process_frame,
    output logic [31:0] o_cnt_match,
    output logic [31:0] o_cnt_nomatch,
    output logic [31:0] o_cnt_bad
);

    nts_state_e state, state_n;
    logic [2:0] idx, idx_n;
    logic       ok, ok_n;
    logic       pulse_n, inc_match, inc_nomatch, inc_bad;
    logic       vld_any, is_bad, is_end, w_ok, last_ok;

    // A simultaneous good and bad strobe counts as bad.
    assign vld_any = |i_rx_data_valid;
    assign is_bad  = i_rx_bad_frame;
    assign is_end  = i_rx_bad_frame | i_rx_good_frame;
    assign w_ok    = word_ok(idx, i_rx_data, i_mac_addr, i_ip_addr, NTP_PORT);
    assign last_ok = vld_any && (idx == LAST_HDR_WORD) && ok && w_ok;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        ok_n        = ok;
        pulse_n     = 1'b0;
        inc_match   = 1'b0;
        inc_nomatch = 1'b0;
        inc_bad     = 1'b0;
        case (state)
            ST_SYNC: begin
                if (!vld_any) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (vld_any) begin
                    idx_n   = 3'd1;
                    ok_n    = word_ok(3'd0, i_rx_data, i_mac_addr, i_ip_addr, NTP_PORT);
                    state_n = (i_rx_data_valid == 8'hff) ? ST_HEADER : ST_DISCARD;
                    if (is_end) begin
                        state_n     = ST_IDLE;
                        inc_bad     = is_bad;
                        inc_nomatch = !is_bad;
                    end
                end
            end
            ST_HEADER: begin
                if (vld_any) begin
                    idx_n = idx + 3'd1;
                    ok_n  = ok & w_ok;
                    if (idx == LAST_HDR_WORD) begin
                        state_n   = ST_DECIDED;
                        pulse_n   = last_ok && !is_bad;
                        inc_match = last_ok && !is_bad;
                    end
                end
                if (is_end) begin
                    state_n     = ST_IDLE;
                    inc_bad     = is_bad;
                    inc_nomatch = !is_bad && !last_ok;
                end
            end
            ST_DECIDED: begin
                if (is_end) begin
                    state_n     = ST_IDLE;
                    inc_bad     = is_bad;
                    inc_nomatch = !is_bad && !ok;
                end
            end
            ST_DISCARD: begin
                if (is_end) begin
                    state_n     = ST_IDLE;
                    inc_bad     = is_bad;
                    inc_nomatch = !is_bad;
                end
            end
            default: state_n = ST_SYNC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state           <= ST_SYNC;
            idx             <= 3'd0;
            ok              <= 1'b0;
            o_process_frame <= 1'b0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            ok              <= ok_n;
            o_process_frame <= pulse_n;
        end
    end

    nts_sat_counter u_cnt_match (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_match), .o_count(o_cnt_match)
    );
    nts_sat_counter u_cnt_nomatch (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_nomatch), .o_count(o_cnt_nomatch)
    );
    nts_sat_counter u_cnt_bad (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_bad), .o_count(o_cnt_bad)
    );

endmodule

// File: doc/nts_rx_preprocessor.md
NTS_RX_PREPROCESSOR -- requirements
Module: nts_rx_preprocessor

Interface
REQ-001 Parameter: NTP_PORT, default 16'd123, UDP destination port that qualifies a frame for processing.
REQ-002 i_clk  in  1  single clock; all logic on its rising edge.
REQ-003 i_reset_n  in  1  reset, synchronous, active-low.
REQ-004 i_rx_data_valid  in  8  MAC byte-lane valid; 8'hff means full word, partial values only on the last word.
REQ-005 i_rx_data  in  64  MAC data; byte 0 of the word in bits [63:56].
REQ-006 i_rx_bad_frame  in  1  end-of-frame strobe, frame in error; coincides with the last word.
REQ-007 i_rx_good_frame  in  1  end-of-frame strobe, frame good; coincides with the last word.
REQ-008 i_mac_addr  in  48  local MAC address; quasi-static.
REQ-009 i_ip_addr  in  32  local IPv4 address; quasi-static.
REQ-010 o_process_frame  out  1  one-cycle pulse: the current frame is an NTP request for this host; feeds the dispatcher front.
REQ-011 o_cnt_match  out  32  saturating count of frames that produced o_process_frame.
REQ-012 o_cnt_nomatch  out  32  saturating count of good-ended frames that did not match.
REQ-013 o_cnt_bad  out  32  saturating count of frames ended by i_rx_bad_frame.

Function
REQ-014 States: SYNC, IDLE, HEADER, DECIDED, DISCARD.
REQ-015 SYNC: stay until a cycle with i_rx_data_valid==0, then go to IDLE; guards against entering mid-frame.
REQ-016 IDLE: data_valid==8'hff is word 0, go to HEADER with word index 1; any other nonzero valid goes to DISCARD.
REQ-017 HEADER: each cycle with nonzero valid increments the 3-bit word index; word 4 is the last checked word.
REQ-018 Checks, byte offsets within the frame:
  - bytes 0-5 == i_mac_addr
  - bytes 12-13 == 16'h0800
  - byte 14 == 8'h45
  - bytes 20-21 & 16'h3fff == 0 (MF clear, offset 0)
  - byte 23 == 8'd17
  - bytes 30-33 == i_ip_addr
  - bytes 36-37 == NTP_PORT
REQ-019 Per-check results shall be registered as each word arrives; no word is stored beyond its check.
REQ-020 Word 4 accepted with all checks passing and no i_rx_bad_frame in that cycle: o_process_frame shall pulse high exactly one cycle later (latency 1) and o_cnt_match shall increment.
REQ-021 After word 4, go to DECIDED, or to IDLE if an end strobe coincides with word 4.
REQ-022 DECIDED: hold until the end strobe, then go to IDLE; no further pulses for the frame.
REQ-023 i_rx_good_frame before word 4 (short frame): no pulse, o_cnt_nomatch increments, go to IDLE.
REQ-024 A frame that fails any check and ends good shall increment o_cnt_nomatch, counted at its end strobe.
REQ-025 i_rx_bad_frame in any state except SYNC: o_cnt_bad increments, go to IDLE, and no pulse for that frame even if word 4 coincides.
REQ-026 DISCARD: go to IDLE on either end strobe and count it per REQ-024/REQ-025.
REQ-027 Counters shall saturate at 32'hffffffff and never wrap.
REQ-028 i_rx_good_frame and i_rx_bad_frame both high in one cycle: treat as bad.
REQ-029 At most one o_process_frame pulse per frame.

Reset
REQ-030 On i_reset_n low at a clock edge: state goes to SYNC, o_process_frame is 0, all counters are 0, and check flags and word index are cleared.
REQ-031 Reset mid-frame shall abandon the frame without counting it; the next frame is recognised only after an idle cycle (REQ-015).

Structure
REQ-032 The shared package nts_pkg shall hold the ethertype, IP version/IHL, UDP protocol number, default NTP port, and state encodings.
REQ-033 One sub-module, nts_sat_counter (32-bit, increment enable, sync active-low reset), shall be instantiated three times.

Verification
REQ-034 Send a 90-byte NTP/UDP frame with matching MAC, IP and dst port 123, ending good: o_process_frame pulses once, 1 cycle after word 4, and o_cnt_match==1.
REQ-035 Send the same frame with dst port 124: no pulse, o_cnt_nomatch==1, o_cnt_match==0.
REQ-036 Send a matching frame with i_rx_bad_frame on word 4: no pulse and o_cnt_bad==1; with i_rx_bad_frame on word 8: one pulse, o_cnt_match==1 and o_cnt_bad==1.
REQ-037 Send a 3-word frame ending good with valid 8'h0f: no pulse, o_cnt_nomatch==1, and the next matching frame pulses.
REQ-038 Assert reset during word 2 while data continues: nothing is counted and no pulse; after an idle cycle a matching frame pulses.
REQ-039 Preload o_cnt_match to 32'hfffffffe via repeated matching frames (or a force), then send 3 more matching frames: count holds at 32'hffffffff.
